// File: rtl/flow_check_pkg.sv
// Shared definitions for the flow result checker: FSM encoding, the
// "no failure seen" index constant and the reference model of device_flow.
package flow_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SUM_W = 64;

  // Callers slice this down to their index width.
  localparam logic [SUM_W-1:0] NO_FAIL = '1;

  // Callers truncate the result to the operand width; modular addition makes
  // truncating once at the end identical to truncating each partial sum.
  function automatic logic [SUM_W-1:0] expected_sum(
    input logic [SUM_W-1:0] a,
    input logic [SUM_W-1:0] b,
    input logic [SUM_W-1:0] c,
    input logic [SUM_W-1:0] d
  );
    return (a + b) + (c + d);
  endfunction

endpackage

// File: rtl/flow_delay_line.sv
// Fixed-latency valid/data shift register that carries expected values
// alongside the device pipeline; a straight wire when LATENCY is zero.
module flow_delay_line #(
  parameter int LATENCY = 0,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              any_valid
);

  if (LATENCY == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst};
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign any_valid = 1'b0;
  end else begin : g_pipe
    logic [LATENCY-1:0] valid_reg;
    logic [DATA_W-1:0]  data_reg [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= '0;
        for (int i = 0; i < LATENCY; i++) data_reg[i] <= '0;
      end else begin
        valid_reg[0] <= in_valid;
        data_reg[0]  <= in_data;
        for (int i = 1; i < LATENCY; i++) begin
          valid_reg[i] <= valid_reg[i-1];
          data_reg[i]  <= data_reg[i-1];
        end
      end
    end

    assign out_valid = valid_reg[LATENCY-1];
    assign out_data  = data_reg[LATENCY-1];
    assign any_valid = |valid_reg;
  end

endmodule

// File: rtl/flow_result_checker.sv
// Compares device_flow results against the reference sum for a programmed
// number of vectors and reports pass/fail counts and the first failing index.
module flow_result_checker
  import flow_check_pkg::*;
#(
  parameter int numberOfBits    = 8,
  parameter int numberOfVectors = 10,
  parameter int latency         = 0,
  parameter int countWidth      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    sampleValid,
  input  logic [numberOfBits-1:0] leftAdderLeftInput,
  input  logic [numberOfBits-1:0] leftAdderRightInput,
  input  logic [numberOfBits-1:0] rightAdderLeftInput,
  input  logic [numberOfBits-1:0] rightAdderRightInput,
  input  logic [numberOfBits-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    testResult,
  output logic [countWidth-1:0]   passCount,
  output logic [countWidth-1:0]   failCount,
  output logic [countWidth-1:0]   firstFailIndex
);

  localparam int DATA_W = numberOfBits + countWidth;
  localparam logic [countWidth-1:0] NO_FAIL_IDX = NO_FAIL[countWidth-1:0];
  localparam logic [countWidth-1:0] LAST_IDX    = countWidth'(numberOfVectors - 1);

  state_t                  state_reg;
  logic [countWidth-1:0]   issue_index_reg;
  logic                    issue;
  logic [numberOfBits-1:0] expected_now;
  logic                    chk_valid;
  logic [DATA_W-1:0]       chk_data;
  logic [numberOfBits-1:0] chk_expected;
  logic [countWidth-1:0]   chk_index;
  logic                    pending;
  logic                    compare;
  logic [countWidth-1:0]   pass_next;
  logic [countWidth-1:0]   fail_next;
  logic [countWidth-1:0]   first_next;

  assign issue = (state_reg == RUN) && sampleValid;
  assign expected_now = numberOfBits'(expected_sum(SUM_W'(leftAdderLeftInput),
                                                   SUM_W'(leftAdderRightInput),
                                                   SUM_W'(rightAdderLeftInput),
                                                   SUM_W'(rightAdderRightInput)));

  flow_delay_line #(
    .LATENCY (latency),
    .DATA_W  (DATA_W)
  ) u_delay (
    .clk       (clock),
    .rst       (reset),
    .in_valid  (issue),
    .in_data   ({expected_now, issue_index_reg}),
    .out_valid (chk_valid),
    .out_data  (chk_data),
    .any_valid (pending)
  );

  assign {chk_expected, chk_index} = chk_data;
  assign compare = chk_valid && ((state_reg == RUN) || (state_reg == DRAIN));

  // Saturating statistics; the first mismatch index latches once per run.
  always_comb begin
    pass_next  = passCount;
    fail_next  = failCount;
    first_next = firstFailIndex;
    if (compare) begin
      if (chk_expected == result) begin
        if (passCount != NO_FAIL_IDX) pass_next = passCount + countWidth'(1);
      end else begin
        if (failCount != NO_FAIL_IDX) fail_next = failCount + countWidth'(1);
        if (firstFailIndex == NO_FAIL_IDX) first_next = chk_index;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      testResult      <= 1'b0;
      passCount       <= '0;
      failCount       <= '0;
      firstFailIndex  <= NO_FAIL_IDX;
      issue_index_reg <= '0;
    end else begin
      passCount      <= pass_next;
      failCount      <= fail_next;
      firstFailIndex <= first_next;
      if (issue) issue_index_reg <= issue_index_reg + countWidth'(1);
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg       <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            testResult      <= 1'b0;
            passCount       <= '0;
            failCount       <= '0;
            firstFailIndex  <= NO_FAIL_IDX;
            issue_index_reg <= '0;
          end
        end
        RUN: begin
          if (issue && (issue_index_reg == LAST_IDX)) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!pending) begin
            state_reg  <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            testResult <= (fail_next == '0);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_result_checker.sv
// Directed bench: a combinational-device checker (u0) and a 2-cycle-latency
// checker (u2) share stimulus; each task checks its own scenario inline.
module tb_flow_result_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sampleValid = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0, d = '0;
  logic [7:0] result0 = '0;
  logic [7:0] d1 = '0, result2 = '0;

  logic       busy0, done0, tr0, busy2, done2, tr2;
  logic [7:0] pass0, fail0, ffi0, pass2, fail2, ffi2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  // Model of a 2-stage pipelined device feeding u2.
  always @(posedge clock) begin
    d1      <= 8'(a + b + c + d);
    result2 <= d1;
  end

  flow_result_checker #(.numberOfBits(8), .numberOfVectors(10), .latency(0), .countWidth(8)) u0 (
    .clock(clock), .reset(reset), .start(start), .sampleValid(sampleValid),
    .leftAdderLeftInput(a), .leftAdderRightInput(b),
    .rightAdderLeftInput(c), .rightAdderRightInput(d), .result(result0),
    .busy(busy0), .done(done0), .testResult(tr0),
    .passCount(pass0), .failCount(fail0), .firstFailIndex(ffi0));

  flow_result_checker #(.numberOfBits(8), .numberOfVectors(10), .latency(2), .countWidth(8)) u2 (
    .clock(clock), .reset(reset), .start(start), .sampleValid(sampleValid),
    .leftAdderLeftInput(a), .leftAdderRightInput(b),
    .rightAdderLeftInput(c), .rightAdderRightInput(d), .result(result2),
    .busy(busy2), .done(done2), .testResult(tr2),
    .passCount(pass2), .failCount(fail2), .firstFailIndex(ffi2));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_vec(input int v, input logic [7:0] res);
    a = 8'(v); b = 8'(v); c = 8'(v); d = 8'(v);
    result0 = res;
    sampleValid = 1'b1;
    step();
    sampleValid = 1'b0;
    $display("[TB] vec operands=%0d result0=%0d pass0=%0d fail0=%0d", v, res, pass0, fail0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy0); end
    tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done0); end
    tests++; if (tr0 !== 1'b0) begin fails++; $display("FAIL reset_test_result got %b want 0", tr0); end
    tests++; if (pass0 !== 8'd0) begin fails++; $display("FAIL reset_pass got %0d want 0", pass0); end
    tests++; if (fail0 !== 8'd0) begin fails++; $display("FAIL reset_fail got %0d want 0", fail0); end
    tests++; if (ffi0 !== 8'd255) begin fails++; $display("FAIL reset_first_fail got %0d want 255", ffi0); end
    tests++; if (ffi2 !== 8'd255) begin fails++; $display("FAIL reset_first_fail_l2 got %0d want 255", ffi2); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_all_pass();
    pulse_start();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL all_pass_busy got %b want 1", busy0); end
    for (int i = 0; i < 10; i++) send_vec(i, 8'(4 * i));
    tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL all_pass_drain_done got %b want 0", done0); end
    tests++; if (pass0 !== 8'd10) begin fails++; $display("FAIL all_pass_drain_pass got %0d want 10", pass0); end
    step();
    tests++; if (done0 !== 1'b1) begin fails++; $display("FAIL all_pass_done got %b want 1", done0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL all_pass_busy_end got %b want 0", busy0); end
    tests++; if (tr0 !== 1'b1) begin fails++; $display("FAIL all_pass_test_result got %b want 1", tr0); end
    tests++; if (fail0 !== 8'd0) begin fails++; $display("FAIL all_pass_fail got %0d want 0", fail0); end
    tests++; if (ffi0 !== 8'd255) begin fails++; $display("FAIL all_pass_first_fail got %0d want 255", ffi0); end
  endtask

  task automatic test_single_error();
    pulse_start();
    tests++; if (pass0 !== 8'd0) begin fails++; $display("FAIL single_err_cleared got %0d want 0", pass0); end
    for (int i = 0; i < 10; i++) send_vec(i, (i == 3) ? 8'(4 * i) ^ 8'd1 : 8'(4 * i));
    step();
    tests++; if (pass0 !== 8'd9) begin fails++; $display("FAIL single_err_pass got %0d want 9", pass0); end
    tests++; if (fail0 !== 8'd1) begin fails++; $display("FAIL single_err_fail got %0d want 1", fail0); end
    tests++; if (ffi0 !== 8'd3) begin fails++; $display("FAIL single_err_first_fail got %0d want 3", ffi0); end
    tests++; if (tr0 !== 1'b0) begin fails++; $display("FAIL single_err_test_result got %b want 0", tr0); end
    tests++; if (done0 !== 1'b1) begin fails++; $display("FAIL single_err_done got %b want 1", done0); end
  endtask

  task automatic test_overflow();
    pulse_start();
    send_vec(100, 8'd144);
    tests++; if (pass0 !== 8'd1) begin fails++; $display("FAIL overflow_pass got %0d want 1", pass0); end
    tests++; if (fail0 !== 8'd0) begin fails++; $display("FAIL overflow_fail0 got %0d want 0", fail0); end
    send_vec(100, 8'd145);
    tests++; if (fail0 !== 8'd1) begin fails++; $display("FAIL overflow_fail got %0d want 1", fail0); end
    tests++; if (ffi0 !== 8'd1) begin fails++; $display("FAIL overflow_first_fail got %0d want 1", ffi0); end
    for (int i = 2; i < 10; i++) send_vec(i, 8'(4 * i));
    step();
    tests++; if (pass0 !== 8'd9) begin fails++; $display("FAIL overflow_pass_end got %0d want 9", pass0); end
    tests++; if (tr0 !== 1'b0) begin fails++; $display("FAIL overflow_test_result got %b want 0", tr0); end
  endtask

  task automatic test_latency2();
    do_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_vec(i, 8'(4 * i));
      if (i < 9) step();
    end
    step();
    tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL lat2_busy_t1 got %b want 1", busy2); end
    tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL lat2_done_t1 got %b want 0", done2); end
    tests++; if (pass2 !== 8'd9) begin fails++; $display("FAIL lat2_pass_t1 got %0d want 9", pass2); end
    step();
    tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL lat2_busy_t2 got %b want 1", busy2); end
    tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL lat2_done_t2 got %b want 0", done2); end
    tests++; if (pass2 !== 8'd10) begin fails++; $display("FAIL lat2_pass_t2 got %0d want 10", pass2); end
    step();
    tests++; if (done2 !== 1'b1) begin fails++; $display("FAIL lat2_done_t3 got %b want 1", done2); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL lat2_busy_t3 got %b want 0", busy2); end
    tests++; if (tr2 !== 1'b1) begin fails++; $display("FAIL lat2_test_result got %b want 1", tr2); end
    tests++; if (fail2 !== 8'd0) begin fails++; $display("FAIL lat2_fail got %0d want 0", fail2); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) send_vec(i, 8'(4 * i));
    tests++; if (pass0 !== 8'd5) begin fails++; $display("FAIL midrun_pre_pass got %0d want 5", pass0); end
    reset = 1'b1;
    #1;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL midrun_busy got %b want 0", busy0); end
    tests++; if (pass0 !== 8'd0) begin fails++; $display("FAIL midrun_pass got %0d want 0", pass0); end
    tests++; if (ffi0 !== 8'd255) begin fails++; $display("FAIL midrun_first_fail got %0d want 255", ffi0); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL midrun_busy_l2 got %b want 0", busy2); end
    start = 1'b1;
    step();
    start = 1'b0;
    reset = 1'b0;
    step();
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL start_with_reset_busy got %b want 0", busy0); end
    pulse_start();
    for (int i = 0; i < 10; i++) send_vec(i, 8'(4 * i));
    step();
    tests++; if (pass0 !== 8'd10) begin fails++; $display("FAIL midrun_rerun_pass got %0d want 10", pass0); end
    tests++; if (done0 !== 1'b1) begin fails++; $display("FAIL midrun_rerun_done got %b want 1", done0); end
    step();
    step();
    tests++; if (pass2 !== 8'd10) begin fails++; $display("FAIL midrun_rerun_pass_l2 got %0d want 10", pass2); end
    tests++; if (done2 !== 1'b1) begin fails++; $display("FAIL midrun_rerun_done_l2 got %b want 1", done2); end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) send_vec(i, 8'(4 * i));
    pulse_start();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL ign_run_start_busy got %b want 1", busy0); end
    tests++; if (pass0 !== 8'd3) begin fails++; $display("FAIL ign_run_start_pass got %0d want 3", pass0); end
    for (int i = 3; i < 10; i++) send_vec(i, 8'(4 * i));
    step();
    tests++; if (done0 !== 1'b1) begin fails++; $display("FAIL ign_done got %b want 1", done0); end
    tests++; if (pass0 !== 8'd10) begin fails++; $display("FAIL ign_pass got %0d want 10", pass0); end
    send_vec(1, 8'hFF);
    step();
    tests++; if (pass0 !== 8'd10) begin fails++; $display("FAIL ign_done_sv_pass got %0d want 10", pass0); end
    tests++; if (fail0 !== 8'd0) begin fails++; $display("FAIL ign_done_sv_fail got %0d want 0", fail0); end
    tests++; if (tr0 !== 1'b1) begin fails++; $display("FAIL ign_done_sv_test_result got %b want 1", tr0); end
    pulse_start();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL restart_busy got %b want 1", busy0); end
    tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL restart_done got %b want 0", done0); end
    tests++; if (pass0 !== 8'd0) begin fails++; $display("FAIL restart_pass got %0d want 0", pass0); end
    tests++; if (tr0 !== 1'b0) begin fails++; $display("FAIL restart_test_result got %b want 0", tr0); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_single_error();
    test_overflow();
    test_latency2();
    test_reset_midrun();
    test_ignored_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
